// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, funct3 encodings,
// write masks and the decoded layout of instruction bits [31:12].
package csr_pkg;

  localparam logic [11:0] CSR_FFLAGS   = 12'h001;
  localparam logic [11:0] CSR_FRM      = 12'h002;
  localparam logic [11:0] CSR_FCSR     = 12'h003;
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MISA     = 12'h301;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;
  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_MHARTID  = 12'hF14;

  typedef enum logic [2:0] {
    F3_NONE  = 3'b000,
    CSRRW    = 3'b001,
    CSRRS    = 3'b010,
    CSRRC    = 3'b011,
    F3_NONEI = 3'b100,
    CSRRWI   = 3'b101,
    CSRRSI   = 3'b110,
    CSRRCI   = 3'b111
  } funct3_e;

  typedef struct packed {
    logic [11:0] addr;
    logic [4:0]  rs1;
    funct3_e     funct3;
  } instr_t;

  localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [31:0] MSTATUS_MPP   = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [31:0] MTVEC_WMASK   = 32'hFFFF_FFFD;
  localparam logic [31:0] MEPC_WMASK    = 32'hFFFF_FFFC;

endpackage

// File: rtl/csr_unit_if.sv
// CSR access port between the execute/writeback control and the CSR file.
interface csr_unit_if;
  logic        we;
  logic [19:0] instr_31_12;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        illegal;

  modport master (output we, instr_31_12, wd, input rd, illegal);
  modport slave  (input we, instr_31_12, wd, output rd, illegal);
endinterface

// File: rtl/csr_alu.sv
// Operand select and RW/RS/RC new-value computation; o_wr is low for
// no-op encodings and for set/clear with a zero rs1/uimm field.
module csr_alu
  import csr_pkg::*;
(
  input  funct3_e     i_funct3,
  input  logic [4:0]  i_rs1,
  input  logic [31:0] i_wd,
  input  logic [31:0] i_old,
  output logic [31:0] o_new,
  output logic        o_wr
);

  logic [2:0]  w_f3;
  logic [31:0] w_op;
  logic        w_rs1_nz;

  assign w_f3     = i_funct3;
  assign w_op     = w_f3[2] ? {27'b0, i_rs1} : i_wd;
  assign w_rs1_nz = (i_rs1 != 5'd0);

  always_comb begin
    o_new = i_old;
    o_wr  = 1'b0;
    case (w_f3[1:0])
      2'b01: begin o_new = w_op;           o_wr = 1'b1;     end
      2'b10: begin o_new = i_old | w_op;   o_wr = w_rs1_nz; end
      2'b11: begin o_new = i_old & ~w_op;  o_wr = w_rs1_nz; end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file (Zicsr subset) for a single-hart RV32 core.
// Define CSR_COUNTERS_EN to add mcycle/mcycleh and the cycle/cycleh shadows.
module csr_unit
  import csr_pkg::*;
#(
  parameter logic [31:0] HART_ID  = 32'd0,
  parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
  input logic       clk,
  input logic       rst,
  csr_unit_if.slave bus
);

  instr_t      w_instr;
  logic [11:0] w_addr;
  logic [31:0] w_rd;
  logic        w_impl;
  logic        w_ro;
  logic [31:0] w_new;
  logic        w_alu_wr;
  logic        w_wr;

  logic [4:0]  r_fflags;
  logic [2:0]  r_frm;
  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
`ifdef CSR_COUNTERS_EN
  logic [63:0] r_cycle;
`endif

  assign w_instr = bus.instr_31_12;
  assign w_addr  = w_instr.addr;
  assign w_ro    = (w_addr[11:10] == 2'b11);

  always_comb begin
    w_rd   = '0;
    w_impl = 1'b1;
    case (w_addr)
      CSR_FFLAGS:   w_rd = {27'b0, r_fflags};
      CSR_FRM:      w_rd = {29'b0, r_frm};
      CSR_FCSR:     w_rd = {24'b0, r_frm, r_fflags};
      CSR_MSTATUS:  w_rd = MSTATUS_MPP | {24'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
      CSR_MISA:     w_rd = MISA_VAL;
      CSR_MIE:      w_rd = r_mie;
      CSR_MTVEC:    w_rd = r_mtvec;
      CSR_MSCRATCH: w_rd = r_mscratch;
      CSR_MEPC:     w_rd = r_mepc;
      CSR_MCAUSE:   w_rd = r_mcause;
      CSR_MTVAL:    w_rd = r_mtval;
      CSR_MIP:      w_rd = '0;
      CSR_MHARTID:  w_rd = HART_ID;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE, CSR_CYCLE:   w_rd = r_cycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH: w_rd = r_cycle[63:32];
`endif
      default:      w_impl = 1'b0;
    endcase
  end

  csr_alu u_alu (
    .i_funct3 (w_instr.funct3),
    .i_rs1    (w_instr.rs1),
    .i_wd     (bus.wd),
    .i_old    (w_rd),
    .o_new    (w_new),
    .o_wr     (w_alu_wr)
  );

  // Read-only space only faults on an effective write; set/clear with x0 is a legal read.
  assign w_wr        = bus.we & w_alu_wr & w_impl & ~w_ro;
  assign bus.illegal = bus.we & (~w_impl | (w_ro & w_alu_wr));
  assign bus.rd      = w_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fflags       <= '0;
      r_frm          <= '0;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mie          <= '0;
      r_mtvec        <= '0;
      r_mscratch     <= '0;
      r_mepc         <= '0;
      r_mcause       <= '0;
      r_mtval        <= '0;
    end else if (w_wr) begin
      case (w_addr)
        CSR_FFLAGS:   r_fflags <= w_new[4:0];
        CSR_FRM:      r_frm    <= w_new[2:0];
        CSR_FCSR:     {r_frm, r_fflags} <= w_new[7:0];
        CSR_MSTATUS: begin
          r_mstatus_mie  <= w_new[3];
          r_mstatus_mpie <= w_new[7];
        end
        CSR_MIE:      r_mie      <= w_new & MIE_WMASK;
        CSR_MTVEC:    r_mtvec    <= w_new & MTVEC_WMASK;
        CSR_MSCRATCH: r_mscratch <= w_new;
        CSR_MEPC:     r_mepc     <= w_new & MEPC_WMASK;
        CSR_MCAUSE:   r_mcause   <= w_new;
        CSR_MTVAL:    r_mtval    <= w_new;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  // Free-running increment first; an explicit write then overrides its half.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_wr && (w_addr == CSR_MCYCLE))  r_cycle[31:0]  <= w_new;
      if (w_wr && (w_addr == CSR_MCYCLEH)) r_cycle[63:32] <= w_new;
    end
  end
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit; counter checks build only with CSR_COUNTERS_EN.
module tb_csr_unit;

  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  csr_unit_if bus ();

  csr_unit #(
    .HART_ID  (32'd0),
    .MISA_VAL (32'h4000_0100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic we, input logic [11:0] addr, input logic [4:0] rs1,
                       input logic [2:0] f3, input logic [31:0] wd);
    bus.we          = we;
    bus.instr_31_12 = {addr, rs1, f3};
    bus.wd          = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 12'h300, 5'd0, 3'b000, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b0, 12'h300, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0000_1800) begin bad++; $display("FAIL reset_mstatus got=%h exp=%h", bus.rd, 32'h0000_1800); end
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
    drive(1'b0, 12'h340, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL reset_mscratch got=%h exp=0", bus.rd); end
    drive(1'b0, 12'h301, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h4000_0100) begin bad++; $display("FAIL reset_misa got=%h exp=40000100", bus.rd); end
  endtask

  task automatic test_fflags();
    bus.we = 1'b1; bus.instr_31_12 = 20'h00109; bus.wd = 32'd3; #1;
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL fflags_old got=%h exp=0", bus.rd); end
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL fflags_illegal got=%b exp=0", bus.illegal); end
    tick();
    drive(1'b0, 12'h001, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h3) begin bad++; $display("FAIL fflags_new got=%h exp=3", bus.rd); end
    drive(1'b0, 12'h003, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h3) begin bad++; $display("FAIL fcsr_alias got=%h exp=3", bus.rd); end
    drive(1'b1, 12'h003, 5'd1, 3'b001, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 12'h002, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h7) begin bad++; $display("FAIL frm_alias got=%h exp=7", bus.rd); end
    drive(1'b0, 12'h003, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'hFF) begin bad++; $display("FAIL fcsr_mask got=%h exp=ff", bus.rd); end
  endtask

  task automatic test_rmw();
    drive(1'b1, 12'h340, 5'd1, 3'b001, 32'hA5A5_0F0F);
    tick();
    drive(1'b1, 12'h340, 5'd2, 3'b010, 32'h0000_F000);
    total++; if (bus.rd !== 32'hA5A5_0F0F) begin bad++; $display("FAIL rs_old got=%h exp=a5a50f0f", bus.rd); end
    tick();
    drive(1'b0, 12'h340, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'hA5A5_FF0F) begin bad++; $display("FAIL rs_new got=%h exp=a5a5ff0f", bus.rd); end
    drive(1'b1, 12'h340, 5'd3, 3'b011, 32'hA5A5_0000);
    tick();
    drive(1'b0, 12'h340, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0000_FF0F) begin bad++; $display("FAIL rc_new got=%h exp=0000ff0f", bus.rd); end
  endtask

  task automatic test_imm_masks();
    drive(1'b1, 12'h300, 5'd8, 3'b110, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 12'h300, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0000_1808) begin bad++; $display("FAIL csrrsi_mstatus got=%h exp=00001808", bus.rd); end
    drive(1'b1, 12'h305, 5'd3, 3'b101, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 12'h305, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h1) begin bad++; $display("FAIL csrrwi_mtvec got=%h exp=1", bus.rd); end
    drive(1'b1, 12'h341, 5'd1, 3'b001, 32'h0000_1237);
    tick();
    drive(1'b0, 12'h341, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0000_1234) begin bad++; $display("FAIL mepc_mask got=%h exp=1234", bus.rd); end
    drive(1'b1, 12'h304, 5'd1, 3'b001, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 12'h304, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0000_0888) begin bad++; $display("FAIL mie_mask got=%h exp=888", bus.rd); end
    drive(1'b1, 12'h344, 5'd1, 3'b001, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 12'h344, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL mip_ignored got=%h exp=0", bus.rd); end
  endtask

  task automatic test_suppress_ro();
    drive(1'b1, 12'h340, 5'd0, 3'b010, 32'hFFFF_FFFF);
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL rs_x0_illegal got=%b exp=0", bus.illegal); end
    tick();
    drive(1'b1, 12'h340, 5'd0, 3'b111, 32'h0);
    tick();
    drive(1'b1, 12'h340, 5'd7, 3'b000, 32'h1234_5678);
    tick();
    drive(1'b0, 12'h340, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0000_FF0F) begin bad++; $display("FAIL suppressed_mscratch got=%h exp=0000ff0f", bus.rd); end
    drive(1'b1, 12'hF14, 5'd1, 3'b001, 32'hDEAD_BEEF);
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL mhartid_rd got=%h exp=0", bus.rd); end
    total++; if (bus.illegal !== 1'b1) begin bad++; $display("FAIL mhartid_illegal got=%b exp=1", bus.illegal); end
    tick();
    drive(1'b1, 12'hF14, 5'd0, 3'b010, 32'hFFFF_FFFF);
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL mhartid_read_illegal got=%b exp=0", bus.illegal); end
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL mhartid_after got=%h exp=0", bus.rd); end
    tick();
  endtask

  task automatic test_illegal_addr();
    drive(1'b1, 12'h7C0, 5'd1, 3'b001, 32'hFFFF_FFFF);
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL unimpl_rd got=%h exp=0", bus.rd); end
    total++; if (bus.illegal !== 1'b1) begin bad++; $display("FAIL unimpl_illegal got=%b exp=1", bus.illegal); end
    drive(1'b0, 12'h7C0, 5'd1, 3'b001, 32'hFFFF_FFFF);
    total++; if (bus.illegal !== 1'b0) begin bad++; $display("FAIL unimpl_no_we got=%b exp=0", bus.illegal); end
`ifndef CSR_COUNTERS_EN
    drive(1'b1, 12'hB00, 5'd0, 3'b010, 32'h0);
    total++; if (bus.illegal !== 1'b1) begin bad++; $display("FAIL mcycle_absent got=%b exp=1", bus.illegal); end
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL mcycle_absent_rd got=%h exp=0", bus.rd); end
`endif
  endtask

  task automatic test_reset_midseq();
    rst = 1'b1;
    drive(1'b1, 12'h340, 5'd1, 3'b001, 32'hDEAD_BEEF);
    tick();
    rst = 1'b0;
    drive(1'b0, 12'h340, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL rst_mscratch got=%h exp=0", bus.rd); end
    drive(1'b0, 12'h003, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL rst_fcsr got=%h exp=0", bus.rd); end
    drive(1'b0, 12'h300, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0000_1800) begin bad++; $display("FAIL rst_mstatus got=%h exp=1800", bus.rd); end
    drive(1'b0, 12'h305, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL rst_mtvec got=%h exp=0", bus.rd); end
    drive(1'b0, 12'h341, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL rst_mepc got=%h exp=0", bus.rd); end
    drive(1'b0, 12'h304, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL rst_mie got=%h exp=0", bus.rd); end
  endtask

`ifdef CSR_COUNTERS_EN
  task automatic test_counters();
    rst = 1'b1;
    drive(1'b0, 12'hB00, 5'd0, 3'b000, 32'h0);
    tick();
    rst = 1'b0;
    drive(1'b0, 12'hB00, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'd0) begin bad++; $display("FAIL mcycle_reset got=%h exp=0", bus.rd); end
    tick();
    total++; if (bus.rd !== 32'd1) begin bad++; $display("FAIL mcycle_inc1 got=%h exp=1", bus.rd); end
    tick();
    total++; if (bus.rd !== 32'd2) begin bad++; $display("FAIL mcycle_inc2 got=%h exp=2", bus.rd); end
    drive(1'b1, 12'hB00, 5'd1, 3'b001, 32'hFFFF_FFFF);
    tick();
    drive(1'b0, 12'hB00, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mcycle_write got=%h exp=ffffffff", bus.rd); end
    tick();
    total++; if (bus.rd !== 32'h0) begin bad++; $display("FAIL mcycle_wrap got=%h exp=0", bus.rd); end
    drive(1'b0, 12'hB80, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h1) begin bad++; $display("FAIL mcycleh_carry got=%h exp=1", bus.rd); end
    drive(1'b0, 12'hC80, 5'd0, 3'b000, 32'h0);
    total++; if (bus.rd !== 32'h1) begin bad++; $display("FAIL cycleh_shadow got=%h exp=1", bus.rd); end
    drive(1'b1, 12'hC00, 5'd1, 3'b001, 32'h0);
    total++; if (bus.illegal !== 1'b1) begin bad++; $display("FAIL cycle_ro_illegal got=%b exp=1", bus.illegal); end
    drive(1'b0, 12'h000, 5'd0, 3'b000, 32'h0);
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.we = 1'b0;
    bus.instr_31_12 = '0;
    bus.wd = '0;
    test_reset();
    test_fflags();
    test_rmw();
    test_imm_masks();
    test_suppress_ro();
    test_illegal_addr();
    test_reset_midseq();
`ifdef CSR_COUNTERS_EN
    test_counters();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
- Machine-mode Control and Status Register file for a single-hart RV32 core, Zicsr subset.
- Decodes the upper 20 bits of a SYSTEM instruction: csr address, rs1/uimm and funct3.
- Returns the old CSR value combinationally.
- Performs the read-modify-write on the rising clock edge when enabled.
- Sits beside the integer register file in the execute/writeback stage.

Parameters:
- HART_ID, 0, value returned by mhartid (0xF14).
- MISA_VAL, 32'h4000_0100, value returned by misa (0x301); RV32I.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  CSR write enable from control; qualifies instruction as a CSR op.
- instr_31_12  input  20  instruction bits [31:12]: [19:8]=csr addr, [7:3]=rs1/uimm, [2:0]=funct3.
- wd  input  32  rs1 register value (source operand).
- rd  output  32  current (pre-write) value of the addressed CSR; combinational.
- illegal  output  1  combinational; high when we=1 and the access is illegal (see Behaviour).

Behaviour:
- Reset values: all writable CSRs are 0, except mstatus.MPP, which reads 2'b11.
- rd is combinational from address and current state. There is no output register, so rd does not depend on rst directly.
- Operand source:
  - funct3[2]=0: operand = wd.
  - funct3[2]=1: operand = zero-extended uimm (instr_31_12[7:3]).
- Operations by funct3[1:0]:
  - 01 RW: new = op.
  - 10 RS: new = old | op.
  - 11 RC: new = old & ~op.
  - 00 (and funct3=100): no operation, no write.
- Write suppression:
  - RS/RC/RSI/RCI perform no write when the rs1/uimm field is 0.
  - RW/RWI always write.
- Write timing: the write occurs at the rising edge when we=1, rst=0, the funct3 is valid, and the address is writable. The new value is visible on rd the following cycle.
- Implemented CSRs (write masks):
  - 0x001 fflags[4:0].
  - 0x002 frm[2:0].
  - 0x003 fcsr = {24'b0, frm, fflags}; writes update both aliased fields.
  - 0x300 mstatus: MIE bit3 and MPIE bit7 writable; MPP[12:11] hardwired 2'b11; other bits 0.
  - 0x304 mie: bits 3, 7, 11 writable.
  - 0x305 mtvec: bit1 forced 0, all other bits writable.
  - 0x340 mscratch: full 32 bits.
  - 0x341 mepc: bits[1:0] forced 0.
  - 0x342 mcause: full 32 bits.
  - 0x343 mtval: full 32 bits.
  - 0x344 mip: reads 0; writes ignored.
  - 0x301 misa and 0xF14 mhartid: read-only, return their parameters.
- Unimplemented address: rd=0, no write, illegal=1.
- Write attempt to a read-only address (addr[11:10]=2'b11) with an actual write: no write, illegal=1.
- Reset asserted together with we: reset wins.

Optional Feature:
- CSR_COUNTERS_EN adds mcycle (0xB00), mcycleh (0xB80), and read-only shadows cycle (0xC00) and cycleh (0xC80).
- With the macro defined:
  - 64-bit counter resets to 0 and increments every cycle.
  - A CSR write to mcycle/mcycleh replaces that half in that cycle; the write wins over the increment.
  - The carry from the low half into the high half wraps normally.
- Without the macro: these addresses are unimplemented (rd=0, illegal=1).

Decomposition:
- Package csr_pkg holds:
  - CSR address localparams.
  - funct3 enum (CSRRW=3'b001, CSRRS=3'b010, CSRRC=3'b011, CSRRWI=3'b101, CSRRSI=3'b110, CSRRCI=3'b111).
  - Write-mask constants.
  - A packed struct for the instr_31_12 fields.
- One sub-module, csr_alu: combinational operand select and RW/RS/RC new-value computation plus the write-suppress flag.
- The register storage and decode remain in csr_unit.

Test Plan:
- After reset: instr_31_12=20'h00109 (CSRRW fflags, rs1=1), wd=3, we=1 -> rd=0 that cycle; next cycle rd=0x3; fcsr (0x003) reads 0x3.
- CSRRW mscratch wd=0xA5A5_0F0F, then CSRRS with wd=0x0000_F000 -> rd=0xA5A5_0F0F; next read 0xA5A5_FF0F. Then CSRRC with wd=0xA5A5_0000 -> next read 0x0000_FF0F.
- CSRRSI mstatus uimm=8 -> mstatus reads 0x0000_1808. CSRRWI mtvec uimm=3 -> mtvec reads 0x1.
- CSRRS mscratch with rs1 field=0 and wd=0xFFFF_FFFF -> no change. CSRRW to mhartid -> rd=HART_ID, illegal=1, value unchanged.
- Access to 0x7C0 -> rd=0, illegal=1. Assert rst mid-sequence with we=1 -> all writable CSRs return to reset values the next cycle.
- With CSR_COUNTERS_EN: mcycle increments by 1 per clock. CSRRW mcycle=0xFFFF_FFFF -> after 1 clock mcycle=0 and mcycleh=1.
